// File: rtl/pipelined_cla_adder.sv
// rtl/pipelined_cla_adder.sv - pipelined carry-lookahead adder/subtractor with valid/ready handshake
// Carry chain cut into NUM_STAGES slices of 4-bit lookahead groups; operands skewed, sums deskewed.
module pipelined_cla_adder #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_STAGES = 4,
    parameter bit SATURATE   = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    inValid,
    output logic                    inReady,
    input  logic [2*DATA_WIDTH-1:0] inData_A,
    input  logic [2*DATA_WIDTH-1:0] inData_B,
    input  logic                    cin,
    input  logic                    inSub,
    output logic                    outValid,
    input  logic                    outReady,
    output logic [2*DATA_WIDTH-1:0] outData,
    output logic                    cout,
    output logic                    ovf
);
    localparam int W   = 2 * DATA_WIDTH;
    localparam int NG  = W / 4;
    localparam int GPS = NG / NUM_STAGES;
    localparam int SW  = 4 * GPS;

    function automatic logic grp_g(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p, g;
        p = a ^ b;
        g = a & b;
        return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    endfunction

    function automatic logic grp_p(input logic [3:0] a, input logic [3:0] b);
        return &(a ^ b);
    endfunction

    function automatic logic [3:0] cla4_sum(input logic [3:0] a, input logic [3:0] b, input logic c);
        logic [3:0] p, g, cy;
        p = a ^ b;
        g = a & b;
        cy[0] = c;
        cy[1] = g[0] | (p[0] & c);
        cy[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
        cy[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
        return p ^ cy;
    endfunction

    logic         adv;
    logic [W-1:0] r_a   [NUM_STAGES];
    logic [W-1:0] r_b   [NUM_STAGES];
    logic [W-1:0] r_sum [NUM_STAGES];
    logic [W-1:0] nx_a  [NUM_STAGES];
    logic [W-1:0] nx_b  [NUM_STAGES];
    logic [W-1:0] nx_sum[NUM_STAGES];
    logic         r_c   [NUM_STAGES];
    logic         r_v   [NUM_STAGES];
    logic         r_sub [NUM_STAGES];
    logic         nx_c  [NUM_STAGES];
    logic         nx_v  [NUM_STAGES];
    logic         nx_sub[NUM_STAGES];
    logic         r_ovf;
    logic         nx_ovf;

    assign adv     = !outValid || outReady;
    assign inReady = adv;

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        logic [W-1:0] a_in, b_in, sum_in, sum_k;
        logic         c_in, v_in, sub_in;
        logic [GPS:0] gc;

        if (k == 0) begin : g_entry
            assign a_in   = inData_A;
            assign b_in   = inSub ? ~inData_B : inData_B;
            assign c_in   = inSub | cin;
            assign v_in   = inValid;
            assign sub_in = inSub;
            assign sum_in = '0;
        end else begin : g_link
            assign a_in   = r_a[k-1];
            assign b_in   = r_b[k-1];
            assign c_in   = r_c[k-1];
            assign v_in   = r_v[k-1];
            assign sub_in = r_sub[k-1];
            assign sum_in = r_sum[k-1];
        end

        always_comb begin
            gc    = '0;
            gc[0] = c_in;
            sum_k = sum_in;
            for (int j = 0; j < GPS; j++) begin
                gc[j+1] = grp_g(a_in[k*SW + 4*j +: 4], b_in[k*SW + 4*j +: 4])
                        | (grp_p(a_in[k*SW + 4*j +: 4], b_in[k*SW + 4*j +: 4]) & gc[j]);
                sum_k[k*SW + 4*j +: 4] = cla4_sum(a_in[k*SW + 4*j +: 4], b_in[k*SW + 4*j +: 4], gc[j]);
            end
        end

        assign nx_a[k]   = a_in;
        assign nx_b[k]   = b_in;
        assign nx_c[k]   = gc[GPS];
        assign nx_v[k]   = v_in;
        assign nx_sub[k] = sub_in;

        if (k == NUM_STAGES - 1) begin : g_final
            logic sat_hi, sat_lo;
            // carry into the MSB recovered from its sum bit and operand bits
            assign nx_ovf    = (sum_k[W-1] ^ a_in[W-1] ^ b_in[W-1]) ^ gc[GPS];
            assign sat_hi    = SATURATE && !sub_in && gc[GPS];
            assign sat_lo    = SATURATE && sub_in && !gc[GPS];
            assign nx_sum[k] = sat_hi ? {W{1'b1}} : (sat_lo ? {W{1'b0}} : sum_k);
        end else begin : g_mid
            assign nx_sum[k] = sum_k;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                r_a[k]   <= '0;
                r_b[k]   <= '0;
                r_sum[k] <= '0;
                r_c[k]   <= 1'b0;
                r_v[k]   <= 1'b0;
                r_sub[k] <= 1'b0;
            end
            r_ovf <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                r_a[k]   <= nx_a[k];
                r_b[k]   <= nx_b[k];
                r_sum[k] <= nx_sum[k];
                r_c[k]   <= nx_c[k];
                r_v[k]   <= nx_v[k];
                r_sub[k] <= nx_sub[k];
            end
            r_ovf <= nx_ovf;
        end
    end

    assign outValid = r_v[NUM_STAGES-1];
    assign outData  = r_sum[NUM_STAGES-1];
    assign cout     = r_c[NUM_STAGES-1];
    assign ovf      = r_ovf;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// tb/tb_pipelined_cla_adder.sv - scoreboard bench for pipelined_cla_adder, four parameter sets
// Instances share stimulus: (NS=4), (NS=2), (NS=1), (NS=4, saturating); each has its own queue.
module tb_pipelined_cla_adder;
    localparam int NSV[4]  = '{4, 2, 1, 4};
    localparam bit SATV[4] = '{1'b0, 1'b0, 1'b0, 1'b1};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic        cin = 1'b0, sub = 1'b0;
    logic        out_ready = 1'b0;

    logic        ir[4], ov[4], co[4], of[4];
    logic [15:0] od[4];

    logic        sn_ir[4], sn_ov[4], sn_co[4], sn_of[4];
    logic [15:0] sn_od[4];
    logic [17:0] q[4][$];
    int          pops[4];
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    pipelined_cla_adder #(.DATA_WIDTH(8), .NUM_STAGES(4), .SATURATE(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .inValid(in_valid), .inReady(ir[0]), .inData_A(a), .inData_B(b),
        .cin(cin), .inSub(sub), .outValid(ov[0]), .outReady(out_ready), .outData(od[0]), .cout(co[0]), .ovf(of[0]));
    pipelined_cla_adder #(.DATA_WIDTH(8), .NUM_STAGES(2), .SATURATE(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .inValid(in_valid), .inReady(ir[1]), .inData_A(a), .inData_B(b),
        .cin(cin), .inSub(sub), .outValid(ov[1]), .outReady(out_ready), .outData(od[1]), .cout(co[1]), .ovf(of[1]));
    pipelined_cla_adder #(.DATA_WIDTH(8), .NUM_STAGES(1), .SATURATE(1'b0)) dut2 (
        .clk(clk), .rst_n(rst_n), .inValid(in_valid), .inReady(ir[2]), .inData_A(a), .inData_B(b),
        .cin(cin), .inSub(sub), .outValid(ov[2]), .outReady(out_ready), .outData(od[2]), .cout(co[2]), .ovf(of[2]));
    pipelined_cla_adder #(.DATA_WIDTH(8), .NUM_STAGES(4), .SATURATE(1'b1)) dut3 (
        .clk(clk), .rst_n(rst_n), .inValid(in_valid), .inReady(ir[3]), .inData_A(a), .inData_B(b),
        .cin(cin), .inSub(sub), .outValid(ov[3]), .outReady(out_ready), .outData(od[3]), .cout(co[3]), .ovf(of[3]));

    // golden result packed as {ovf, cout, data}
    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                          input logic ci, input logic s, input bit sat);
        logic [15:0] yy, d;
        logic        c0;
        logic [16:0] full;
        logic [15:0] low;
        yy   = s ? ~y : y;
        c0   = s ? 1'b1 : ci;
        full = {1'b0, x} + {1'b0, yy} + {16'd0, c0};
        low  = {1'b0, x[14:0]} + {1'b0, yy[14:0]} + {15'd0, c0};
        d    = full[15:0];
        if (sat && !s && full[16]) d = 16'hFFFF;
        if (sat && s && !full[16]) d = 16'h0000;
        return {low[15] ^ full[16], full[16], d};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            sn_ir[i] = ir[i];
            sn_ov[i] = ov[i];
            sn_od[i] = od[i];
            sn_co[i] = co[i];
            sn_of[i] = of[i];
            if (ov[i]) begin
                check($sformatf("out_expected_dut%0d", i), 32'(q[i].size() > 0), 32'd1);
                if (q[i].size() > 0) begin
                    check($sformatf("result_dut%0d", i), {14'd0, of[i], co[i], od[i]}, {14'd0, q[i][0]});
                    if (out_ready) begin
                        void'(q[i].pop_front());
                        pops[i]++;
                    end
                end
            end
            if (in_valid && ir[i]) q[i].push_back(model(a, b, cin, sub, SATV[i]));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int busy;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 30; n++) begin
            busy = 0;
            for (int i = 0; i < 4; i++) busy += q[i].size();
            if (busy == 0) break;
            tick();
        end
        for (int i = 0; i < 4; i++) check($sformatf("drained_dut%0d", i), 32'(q[i].size()), 32'd0);
    endtask

    task automatic run_one(input logic [15:0] x, input logic [15:0] y, input logic ci, input logic s,
                           input logic [15:0] exp_d, input logic exp_c, input logic exp_o,
                           input logic [15:0] exp_sat);
        int lat;
        a = x; b = y; cin = ci; sub = s;
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        for (int n = 1; n <= 10; n++) begin
            tick();
            if (sn_ov[0]) begin
                lat = n;
                break;
            end
        end
        check("latency_ns4", lat, 32'd4);
        check("data_ns4", sn_od[0], exp_d);
        check("cout_ns4", sn_co[0], exp_c);
        check("ovf_ns4", sn_of[0], exp_o);
        check("valid_sat", sn_ov[3], 1'b1);
        check("data_sat", sn_od[3], exp_sat);
        check("cout_sat", sn_co[3], exp_c);
        drain();
    endtask

    initial begin
        int idx;
        int lat[4];
        for (int i = 0; i < 4; i++) pops[i] = 0;

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rst_valid_dut%0d", i), ov[i], 1'b0);
            check($sformatf("rst_data_dut%0d", i), od[i], 16'h0000);
            check($sformatf("rst_flags_dut%0d", i), {co[i], of[i]}, 2'b00);
        end
        rst_n = 1'b1;

        // directed arithmetic cases
        run_one(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'hFFFF);
        run_one(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 16'h0000);
        run_one(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 16'h8000);
        run_one(16'hFFF0, 16'h0020, 1'b0, 1'b0, 16'h0010, 1'b1, 1'b0, 16'hFFFF);
        run_one(16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 16'h0000);
        run_one(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 16'h5556);

        // latency with outReady held high, every instance
        a = 16'h0F0F; b = 16'h00F1; cin = 1'b0; sub = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) lat[i] = 0;
        tick();
        in_valid = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            tick();
            for (int i = 0; i < 4; i++) if (sn_ov[i] && lat[i] == 0) lat[i] = n;
        end
        for (int i = 0; i < 4; i++) check($sformatf("latency_dut%0d", i), lat[i], NSV[i]);
        drain();

        // 8 back-to-back items with a downstream stall in cycles 5..7
        for (int i = 0; i < 4; i++) pops[i] = 0;
        idx = 0;
        for (int cyc = 0; cyc < 14; cyc++) begin
            in_valid  = (idx < 8);
            a         = 16'(idx * 16'h1111 + 16'h0F00);
            b         = 16'(idx * 16'h0203 + 16'hF000);
            sub       = idx[0];
            cin       = idx[1];
            out_ready = !(cyc >= 5 && cyc <= 7);
            tick();
            if (in_valid && sn_ir[0]) idx++;
            if (cyc >= 5 && cyc <= 7) begin
                check($sformatf("stall_inready_c%0d", cyc), sn_ir[0], 1'b0);
                check($sformatf("stall_outvalid_c%0d", cyc), sn_ov[0], 1'b1);
            end else if (cyc <= 10) begin
                check($sformatf("run_inready_c%0d", cyc), sn_ir[0], 1'b1);
            end
        end
        drain();
        check("stall_items_in", idx, 32'd8);
        check("stall_items_out", pops[0], 32'd8);

        // reset with three items in flight
        a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        repeat (3) tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("midrst_valid_dut%0d", i), ov[i], 1'b0);
            q[i].delete();
        end
        #1;
        rst_n = 1'b1;
        for (int n = 0; n < 8; n++) begin
            tick();
            check($sformatf("post_rst_quiet_%0d", n), sn_ov[0], 1'b0);
        end

        // random traffic and backpressure
        for (int n = 0; n < 12000; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            a         = 16'($urandom);
            b         = 16'($urandom);
            cin       = 1'($urandom_range(0, 1));
            sub       = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
